// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one partial-product step per clock, signed or unsigned per transaction.
// Optional debug observation ports are enabled by defining SEQ_MULTIPLIER_DEBUG_EN.
module seq_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
`ifdef SEQ_MULTIPLIER_DEBUG_EN
  output logic               busy,
  output logic [1:0]         dbg_state,
  output logic [CNT_W-1:0]   dbg_cnt,
  output logic               dbg_add,
  output logic               dbg_sub,
  output logic               dbg_x,
  output logic [WIDTH:0]     dbg_sum
`else
  output logic               busy
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d, a_q, a_d, b_q, b_d;
  logic               x_q, x_d, s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               last_s, sub_s, fill_s;
  logic [WIDTH:0]     ext_a_s, ext_m_s, sum_s;

  // Adder: W+1 bits wide so that a -2^(W-1) multiplicand still yields an exact signed product.
  always_comb begin
    last_s  = (cnt_q == CNT_W'(WIDTH - 1));
    sub_s   = b_q[0] & s_q & last_s;
    ext_a_s = s_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    ext_m_s = s_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    if (!b_q[0]) begin
      sum_s = {x_q, a_q};
    end else if (sub_s) begin
      sum_s = ext_a_s - ext_m_s;
    end else begin
      sum_s = ext_a_s + ext_m_s;
    end
    fill_s = s_q ? sum_s[WIDTH] : 1'b0;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    product_d   = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          m_d        = in_a;
          b_d        = in_b;
          a_d        = '0;
          x_d        = 1'b0;
          s_d        = in_signed;
          cnt_d      = '0;
          state_d    = ST_CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_CALC: begin
        x_d   = fill_s;
        a_d   = sum_s[WIDTH:1];
        b_d   = {sum_s[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          product_d   = {sum_s[WIDTH:1], sum_s[0], b_q[WIDTH-1:1]};
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          product_d   = '0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        product_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      m_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= 1'b0;
      s_q         <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      product_q   <= product_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign out_product = product_q;

`ifdef SEQ_MULTIPLIER_DEBUG_EN
  // Combinational observers are gated by CALC so they read zero outside a calculation.
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;
  assign dbg_add   = b_q[0] & (state_q == ST_CALC) & ~sub_s;
  assign dbg_sub   = sub_s & (state_q == ST_CALC);
  assign dbg_x     = x_q;
  assign dbg_sum   = (state_q == ST_CALC) ? sum_s : '0;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and model-checked bench for seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, busy8;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic [15:0] prod8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, busy16;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
  logic [31:0] prod16;

  int n_tests = 0;
  int n_fail  = 0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(a8), .in_b(b8), .in_signed(in_signed), .out_valid(out_valid8),
    .out_ready(out_ready), .out_product(prod8), .busy(busy8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(a16), .in_b(b16), .in_signed(in_signed), .out_valid(out_valid16),
    .out_ready(out_ready), .out_product(prod16), .busy(busy16)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on the selected instance; with hold=1 it returns while DONE is still pending.
  task automatic do_op(input string tag, input bit w16, input bit sgn,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_p, input bit hold);
    int  lat;
    int  wlim;
    bit  rdy_bad;
    wlim = 0;
    while (!(w16 ? in_ready16 : in_ready8) && wlim < 100) begin
      @(posedge Clk); #1;
      wlim++;
    end
    if (w16) begin
      a16 = a; b16 = b; in_valid16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; in_valid8 = 1'b1;
    end
    in_signed = sgn;
    @(posedge Clk); #1;
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16; in_signed = ~in_signed;
    lat = 0;
    rdy_bad = 1'b0;
    while (!(w16 ? out_valid16 : out_valid8) && lat < 64) begin
      if ((w16 ? in_ready16 : in_ready8) || !(w16 ? busy16 : busy8)) rdy_bad = 1'b1;
      @(posedge Clk); #1;
      lat++;
    end
    if (w16 ? in_ready16 : in_ready8) rdy_bad = 1'b1;
    check({tag, " product"}, w16 ? prod16 : {16'h0000, prod8}, exp_p);
    check({tag, " latency"}, 32'(lat), w16 ? 32'd16 : 32'd8);
    check({tag, " in_ready low while busy"}, {31'd0, rdy_bad}, 32'd0);
    if (!hold) begin
      @(posedge Clk); #1;
      check({tag, " released"}, w16 ? {30'd0, out_valid16, in_ready16} : {30'd0, out_valid8, in_ready8}, 32'd1);
    end
  endtask

  initial begin
    logic signed [15:0] s8a, s8b;
    logic signed [31:0] s16a, s16b;
    logic [15:0] r8a, r8b;
    logic [31:0] exp32;
    bit          sgn;
    bit          stable_bad;

    #12;
    check("reset outputs 8", {prod8, 12'd0, in_ready8, out_valid8, busy8, 1'b0}, {16'h0000, 12'd0, 4'b1000});
    check("reset outputs 16", prod16, 32'h0000_0000);
    check("reset flags 16", {29'd0, in_ready16, out_valid16, busy16}, 32'd4);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    do_op("s 7*-3",       1'b0, 1'b1, 16'h0007, 16'h00FD, 32'h0000_FFEB, 1'b0);
    do_op("s -128*-128",  1'b0, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, 1'b0);
    do_op("s -1*-1",      1'b0, 1'b1, 16'h00FF, 16'h00FF, 32'h0000_0001, 1'b0);
    do_op("u 255*255",    1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0);
    do_op("u 0*0xAB",     1'b0, 1'b0, 16'h0000, 16'h00AB, 32'h0000_0000, 1'b0);
    do_op("u 128*2",      1'b0, 1'b0, 16'h0080, 16'h0002, 32'h0000_0100, 1'b0);

    // Backpressure: product must stay frozen while downstream stalls
    out_ready = 1'b0;
    do_op("bp 255*255", 1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b1);
    stable_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (!out_valid8 || in_ready8 || prod8 !== 16'hFE01) stable_bad = 1'b1;
    end
    check("bp stable 20 cycles", {31'd0, stable_bad}, 32'd0);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    check("bp release", {30'd0, out_valid8, in_ready8}, 32'd1);

    // Asynchronous reset in the middle of CALC
    in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; in_signed = 1'b0;
    @(posedge Clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    #2 Reset_n = 1'b0;
    #1;
    check("abort outputs", {prod8, 13'd0, in_ready8, out_valid8, busy8}, {16'h0000, 16'h0004});
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    do_op("after abort s 5*-5", 1'b0, 1'b1, 16'h0005, 16'h00FB, 32'h0000_FFE7, 1'b0);

    do_op("w16 s 0x8000*0x7FFF", 1'b1, 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000, 1'b0);
    do_op("w16 u 0xFFFF*0xFFFF", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      r8a = 16'($urandom_range(0, 65535));
      r8b = 16'($urandom_range(0, 65535));
      sgn = 1'($urandom_range(0, 1));
      if (sgn) begin
        s16a = $signed(r8a); s16b = $signed(r8b);
        exp32 = s16a * s16b;
      end else begin
        exp32 = {16'h0000, r8a} * {16'h0000, r8b};
      end
      do_op("w16 random", 1'b1, sgn, r8a, r8b, exp32, 1'b0);
    end

    for (int i = 0; i < 200; i++) begin
      r8a = 16'($urandom_range(0, 255));
      r8b = 16'($urandom_range(0, 255));
      sgn = 1'($urandom_range(0, 1));
      if (sgn) begin
        s8a = {{8{r8a[7]}}, r8a[7:0]}; s8b = {{8{r8b[7]}}, r8b[7:0]};
        exp32 = {16'h0000, 16'(s8a * s8b)};
      end else begin
        exp32 = {16'h0000, 16'(r8a * r8b)};
      end
      do_op("w8 random", 1'b0, sgn, r8a, r8b, exp32, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
